// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-deep
// valid/ready holding register with single-cycle frame_err / overrun pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 221,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BitReload  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfReload = CntW'(HALF_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            fe_q, fe_d;
    logic            ovr_q, ovr_d;
    logic            rx_meta, rx_s;
    logic            byte_done, frame_bad, cnt_zero;

    // Synchronizer resets to the idle level so reset never fakes a start edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = HalfReload;
                end
            end
            StStart: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    state_d = StIdle;
                end else begin
                    state_d = StData;
                    cnt_d   = BitReload;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // LSB arrives first, so shift right and insert at the top
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = BitReload;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    byte_done = 1'b1;
                    state_d   = StIdle;
                end else begin
                    frame_bad = 1'b1;
                    state_d   = StBreak;
                end
            end
            StBreak: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = frame_bad;
        ovr_d   = 1'b0;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (byte_done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: stimulus pushes expected bytes,
// a negedge monitor pops and compares whenever a new byte is presented.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         last_rise_cyc = -1;
    logic       rise_busy = 1'b0;
    int         n_rx = 0;
    int         fe_high = 0, fe_rise = 0, ovr_high = 0, ovr_rise = 0;
    int         want_fe = 0, want_ovr = 0;
    logic       pv = 1'b0, pr = 1'b0, pfe = 1'b0, povr = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: a new byte is on data when valid rises or is reloaded after acceptance
    always @(negedge clk) begin
        if (resetn && valid && (!pv || pr)) begin
            n_rx++;
            last_rise_cyc = cyc;
            rise_busy     = busy;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_valid: got data 0x%0h, expected no byte", data);
            end else begin
                check("rx_data", int'(data), int'(exp_q.pop_front()));
            end
        end
        pv = valid;
        pr = ready;
        if (frame_err) fe_high++;
        if (frame_err && !pfe) fe_rise++;
        if (overrun) ovr_high++;
        if (overrun && !povr) ovr_rise++;
        pfe  = frame_err;
        povr = overrun;
    end

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        int         rx_before;
        rxd    = 1'b1;
        ready  = 1'b0;
        resetn = 1'b0;
        wait_cyc(3);
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        resetn = 1'b1;
        wait_cyc(5);

        // Single byte, ready low: latency from line fall is 2 sync + 8 + 144 + 1
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_cyc(4);
        check("a5_latency", last_rise_cyc - fall_cyc, 155);
        check("a5_busy_at_valid", int'(rise_busy), 0);
        check("a5_valid_held", int'(valid), 1);
        check("a5_no_frame_err", fe_rise, 0);
        check("a5_no_overrun", ovr_rise, 0);

        // Second byte while still full: overrun, old data kept
        want_ovr++;
        send_frame(8'h3C, 1'b1);
        wait_cyc(4);
        check("ovr_data_kept", int'(data), 8'hA5);
        check("ovr_valid_kept", int'(valid), 1);
        check("ovr_pulse_count", ovr_rise, 1);
        check("ovr_pulse_width", ovr_high, 1);
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
        check("accept_clears_valid", int'(valid), 0);

        // Back-to-back frames, zero idle gap
        ready     = 1'b1;
        rx_before = n_rx;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cyc(30);
        check("b2b_count", n_rx - rx_before, 2);
        check("b2b_no_frame_err", fe_rise, 0);

        // Framing error followed by a held-low line
        want_fe++;
        send_frame(8'h55, 1'b0);
        wait_cyc(100);
        check("break_busy", int'(busy), 1);
        check("break_valid", int'(valid), 0);
        check("break_fe_once", fe_rise, 1);
        rxd = 1'b1;
        wait_cyc(5);
        check("break_exit_busy", int'(busy), 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_cyc(10);

        // Short glitch aborts in START
        rxd = 1'b0;
        wait_cyc(4);
        rxd = 1'b1;
        wait_cyc(2);
        check("glitch_busy", int'(busy), 1);
        wait_cyc(20);
        check("glitch_idle", int'(busy), 0);
        check("glitch_no_valid", int'(valid), 0);

        // Reset during data bit 4; line only rises afterwards
        fork
            send_frame(8'hE5, 1'b1);
            begin
                repeat (CPB * 5 + CPB / 2) @(posedge clk);
                #2;
                resetn = 1'b0;
                #1;
                check("midrst_data", int'(data), 0);
                check("midrst_valid", int'(valid), 0);
                check("midrst_busy", int'(busy), 0);
                check("midrst_frame_err", int'(frame_err), 0);
                check("midrst_overrun", int'(overrun), 0);
                repeat (CPB) @(posedge clk);
                #2;
                resetn = 1'b1;
            end
        join
        wait_cyc(30);
        check("midrst_no_valid", int'(valid), 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_cyc(10);

        // Random frames, some with a bad stop bit and a held-low break
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                want_fe++;
                send_frame(b, 1'b0);
                wait_cyc($urandom_range(0, 40));
                rxd = 1'b1;
                wait_cyc($urandom_range(2, 10));
            end else begin
                exp_q.push_back(b);
                send_frame(b, 1'b1);
                wait_cyc($urandom_range(0, 30));
            end
        end
        wait_cyc(50);

        check("queue_drained", exp_q.size(), 0);
        check("frame_err_count", fe_rise, want_fe);
        check("frame_err_width", fe_high, want_fe);
        check("overrun_count", ovr_rise, want_ovr);
        check("overrun_width", ovr_high, want_ovr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 serial receiver: the receive end of the UART link whose transmit side the CPU core drives on txd.
- Samples the asynchronous rxd pin on the pixel-PLL clock and assembles bytes LSB first.
- Presents each byte on a one-deep valid/ready holding register for the program loader and for CPU input.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 221, clock cycles per bit (25.5 MHz / 115200 baud); legal range 4..4095.
- HALF_BIT, CLKS_PER_BIT/2, offset from the start edge to the start-bit centre.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- rxd  input  1  raw serial line; idles high; asynchronous to clk.
- data  output  8  received byte; held stable while valid=1.
- valid  output  1  holding register full.
- ready  input  1  consumer accepts data on a cycle where valid&&ready.
- busy  output  1  high whenever the state machine is not IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a byte completed while the holding register was still full and not being accepted.

Behaviour:
- Reset is asynchronous, active-low; it is the only clear.
  - On reset: data=0, valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, counters=0.
  - Both synchronizer flops reset to 1.
  - Reset mid-frame abandons the frame with no pulse. After release, the receiver waits in IDLE for a new falling edge.
- Synchronizer: 2-flop chain gives rx_s, which is used everywhere. Start detection sees rxd 2 cycles late.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on rx_s==0 (call this cycle t0), go to START and load the counter.
- START: at t0+HALF_BIT sample rx_s.
  - If 1, it was a glitch: return to IDLE with no pulse.
  - If 0, go to DATA.
- DATA: sample bit i (i=0..7) at t0+HALF_BIT+(i+1)*CLKS_PER_BIT into shift[i] (LSB first). After bit 7, go to STOP.
- STOP: sample at t0+HALF_BIT+9*CLKS_PER_BIT.
  - Sample 1: byte complete; go to IDLE that same cycle, so back-to-back frames are accepted.
  - Sample 0: pulse frame_err on the next cycle, discard the byte, and go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. A held-low line produces exactly one frame_err.
- Holding register, evaluated on the cycle after a good stop sample:
  - valid==0: data<=shift, valid<=1.
  - valid==1 and ready==1 on that cycle: accept the old byte, load the new one, valid stays 1, no overrun.
  - valid==1 and ready==0: keep the old data, drop the new byte, pulse overrun.
- Handshake:
  - valid clears on the cycle after valid&&ready (no new byte completing).
  - ready while valid==0 has no effect.
  - data never changes while valid==1 except on acceptance.
- busy is combinational from the state (state!=IDLE).
- Bit counter is 3 bits. The baud counter is wide enough for CLKS_PER_BIT-1; it reloads on every sample and never wraps silently.

Test Plan (CLKS_PER_BIT=16 for the bench):
- Reset, rxd idle high, then send 0xA5 with ready=0 → valid rises one cycle after the stop sample (t0+8+144+1), data=0xA5, frame_err=overrun=0, busy low again by then.
- Hold valid (ready=0) and send 0x3C → overrun pulses exactly 1 cycle, data stays 0xA5. Then ready=1 for one cycle → valid=0 next cycle.
- Two back-to-back frames 0x00, 0xFF with zero idle gap and ready held 1 → two valid assertions, data 0x00 then 0xFF, no errors.
- Frame 0x55 with the stop bit driven low, rxd held low 100 cycles then high → one frame_err pulse, valid stays 0, busy high until rxd returns high, then the next frame 0x81 is received correctly.
- rxd low glitch of 4 cycles in IDLE → START aborts at t0+8, no valid, busy returns 0.
- Assert resetn low during data bit 4 of a frame, release while rxd is still toggling → all outputs 0 during reset, no spurious valid. The next clean frame 0x7E is received as 0x7E.
